// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: opcodes, sequencer states and the invert-B predicate shared by the serial ALU.
package alu_serial_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SLTFIX, S_DONE} state_t;
  function automatic logic inv_b(input logic [2:0] op);
    return op == OP_SUB || op == OP_SLT;
  endfunction
endpackage

// File: rtl/serial_bit_slice.sv
// serial_bit_slice: combinational one-bit AND/OR/full-adder slice.
module serial_bit_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic y_and,
  output logic y_or,
  output logic sum,
  output logic cout
);
  assign y_and = a & b;
  assign y_or  = a | b;
  assign sum   = a ^ b ^ cin;
  assign cout  = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer, LSB first, with SLT fix-up.
// Define ALU_SERIAL_OVF_EN to build the signed-overflow flag register.
module alu_serial_seq
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, res;
  logic [2:0] op_q;
  logic [CW-1:0] cnt;
  logic carry, cmsb, cout_q;
  logic s_and, s_or, s_sum, s_cout, bit_y, last, addsub;
  serial_bit_slice u_slice (
    .a    (a_q[cnt]),
    .b    (b_q[cnt] ^ inv_b(op_q)),
    .cin  (carry),
    .y_and(s_and),
    .y_or (s_or),
    .sum  (s_sum),
    .cout (s_cout)
  );
  assign last   = cnt == CW'(WIDTH - 1);
  assign addsub = op_q == OP_ADD || op_q == OP_SUB;
  assign bit_y  = op_q == OP_AND ? s_and :
                  op_q == OP_OR  ? s_or  :
                  (addsub || op_q == OP_SLT) ? s_sum : 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == S_IDLE   ? (start ? S_RUN : S_IDLE) :
               state == S_RUN    ? (last ? (op_q == OP_SLT ? S_SLTFIX : S_DONE) : S_RUN) :
               state == S_SLTFIX ? S_DONE : S_IDLE;
  end
  always_comb begin
    ready = state == S_IDLE;
    done  = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_AND;
      cnt    <= '0;
      carry  <= 1'b0;
      cmsb   <= 1'b0;
      cout_q <= 1'b0;
      res    <= '0;
    end else if (state == S_IDLE && start) begin
      a_q   <= a;
      b_q   <= b;
      op_q  <= op;
      cnt   <= '0;
      carry <= inv_b(op);
    end else if (state == S_RUN) begin
      res   <= {bit_y, res[WIDTH-1:1]};
      carry <= s_cout;
      if (last) begin
        cmsb   <= carry;
        cout_q <= addsub & s_cout;
      end else cnt <= cnt + CW'(1);
    end else if (state == S_SLTFIX) begin
      // less-than = sign of (a-b) corrected by signed overflow
      res <= {{(WIDTH-1){1'b0}}, res[WIDTH-1] ^ cmsb ^ carry};
    end
`ifdef ALU_SERIAL_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else if (state == S_IDLE && start) ovf_q <= ovf_q;
    else if (state == S_RUN && last) ovf_q <= addsub & (carry ^ s_cout);
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif
  assign result = res;
  assign zero   = res == '0;
  assign cout   = cout_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: scoreboard bench for alu_serial_seq at WIDTH=8.
module tb_alu_serial_seq;
  localparam int W = 8;
`ifdef ALU_SERIAL_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] res;
    logic co;
    logic ov;
    int lat;
    int t0;
    string nm;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [2:0] op = 0;
  logic [W-1:0] a = 0, b = 0, result;
  logic ready, done, zero, cout, overflow;
  int cyc = 0, checks = 0, errors = 0, dones = 0, n_exp = 0;
  exp_t q[$];
  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .op(op), .a(a), .b(b),
    .result(result), .done(done), .zero(zero), .cout(cout), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && done) begin
      exp_t e;
      dones++;
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk({e.nm, ".result"}, result, e.res);
        chk({e.nm, ".zero"}, zero, e.res == 0);
        chk({e.nm, ".cout"}, cout, e.co);
        chk({e.nm, ".overflow"}, overflow, e.ov);
        chk({e.nm, ".latency"}, cyc - e.t0 + 1, e.lat);
      end
    end
  task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] x, y,
                       input logic [W-1:0] r, input logic co, ov);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    op = o; a = x; b = y; start = 1;
    @(posedge clk);
    #1 start = 0;
    e.res = r; e.co = co; e.ov = ov; e.nm = nm; e.t0 = cyc;
    e.lat = (o == 3'b111) ? W + 2 : W + 1;
    q.push_back(e);
    n_exp++;
  endtask
  task automatic wait_done(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk({nm, ".timeout"}, 1, 0);
      q.delete();
    end
    @(negedge clk);
  endtask
  task automatic run(input string nm, input logic [2:0] o, input logic [W-1:0] x, y,
                     input logic [W-1:0] r, input logic co, ov);
    issue(nm, o, x, y, r, co, ov);
    wait_done(nm);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, ".ready"}, ready, 1);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".result"}, result, 0);
    chk({nm, ".zero"}, zero, 1);
    chk({nm, ".cout"}, cout, 0);
    chk({nm, ".overflow"}, overflow, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1;
    run("add_7f_01", 3'b010, 8'h7f, 8'h01, 8'h80, 0, OVF);
    run("sub_05_05", 3'b110, 8'h05, 8'h05, 8'h00, 1, 0);
    run("slt_fe_03", 3'b111, 8'hfe, 8'h03, 8'h01, 0, 0);
    run("slt_7f_80", 3'b111, 8'h7f, 8'h80, 8'h00, 0, 0);
    run("and_f0_3c", 3'b000, 8'hf0, 8'h3c, 8'h30, 0, 0);
    run("or_f0_0c", 3'b001, 8'hf0, 8'h0c, 8'hfc, 0, 0);
    run("add_ff_01", 3'b010, 8'hff, 8'h01, 8'h00, 1, 0);
    run("illegal_011", 3'b011, 8'hff, 8'hff, 8'h00, 0, 0);
    issue("ignore_start", 3'b010, 8'h7f, 8'h01, 8'h80, 0, OVF);
    repeat (2) @(negedge clk);
    chk("ignore_start.ready", ready, 0);
    a = 8'h11; b = 8'h22; op = 3'b000; start = 1;
    @(negedge clk) start = 0;
    @(negedge clk);
    a = 8'h33; b = 8'h44; op = 3'b110; start = 1;
    @(negedge clk) start = 0;
    wait_done("ignore_start");
    issue("abort", 3'b010, 8'h12, 8'h34, 8'h46, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1 chk_reset("abort_reset");
    q.delete();
    n_exp--;
    repeat (2) @(negedge clk);
    rst_n = 1;
    run("add_01_01", 3'b010, 8'h01, 8'h01, 8'h02, 0, 0);
    chk("done_count", dones, n_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
